// File: rtl/moore_seq_pkg.sv
// State codes shared between the serial pattern transmitter and the detector benches.
package moore_seq_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SHIFT = 3'd1;
    localparam logic [2:0] S_GAP   = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down counter with a zero flag; a decrement at zero holds at zero.
module seq_down_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_c
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_q <= count_q - W'(1);
        end
    end

    assign zero_c = (count_q == '0);

endmodule

// File: rtl/moore_seq_gen.sv
// Moore serial pattern transmitter: sends a captured pattern MSB-first on x,
// with programmable length, repeat count and an idle gap between repeats.
module moore_seq_gen
    import moore_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned LEN_W = 5,
    parameter int unsigned REP_W = 4,
    parameter int unsigned GAP   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [REP_W-1:0] reps,
    output logic             x,
    output logic             busy,
    output logic             done,
    output logic [2:0]       out
);

    localparam int unsigned GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int unsigned GAP_LOAD = (GAP > 0) ? GAP - 1 : 0;

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             x_q, x_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [LEN_W-1:0] len_c;
    logic [WIDTH-1:0] aligned_c;
    logic             bit_ld, bit_dec, bit_zero;
    logic [LEN_W-1:0] bit_val;
    logic             rep_ld, rep_dec, rep_zero;
    logic             gap_ld, gap_dec, gap_zero;
    logic             reload;

    // Clamp length, then left-align the pattern so the first bit sits at the MSB
    assign len_c     = (len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : len;
    assign aligned_c = pattern << (LEN_W'(WIDTH) - len_c);

    seq_down_counter #(.W(LEN_W)) u_bit_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (bit_ld),
        .load_val_i (bit_val),
        .dec_i      (bit_dec),
        .zero_c     (bit_zero)
    );

    seq_down_counter #(.W(REP_W)) u_rep_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (rep_ld),
        .load_val_i (reps),
        .dec_i      (rep_dec),
        .zero_c     (rep_zero)
    );

    seq_down_counter #(.W(GAP_W)) u_gap_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (gap_ld),
        .load_val_i (GAP_W'(GAP_LOAD)),
        .dec_i      (gap_dec),
        .zero_c     (gap_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            sh_q    <= '0;
            pat_q   <= '0;
            len_q   <= '0;
            x_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            x_q     <= x_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next state; outputs are derived from the next state so they register with it
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        pat_d   = pat_q;
        len_d   = len_q;
        x_d     = 1'b0;
        bit_ld  = 1'b0;
        bit_val = len_q - LEN_W'(1);
        bit_dec = 1'b0;
        rep_ld  = 1'b0;
        rep_dec = 1'b0;
        gap_ld  = 1'b0;
        gap_dec = 1'b0;
        reload  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pat_d  = aligned_c;
                    len_d  = len_c;
                    rep_ld = 1'b1;
                    if (len_c == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SHIFT;
                        x_d     = aligned_c[WIDTH-1];
                        sh_d    = {aligned_c[WIDTH-2:0], 1'b0};
                        bit_ld  = 1'b1;
                        bit_val = len_c - LEN_W'(1);
                    end
                end
            end
            S_SHIFT: begin
                if (!bit_zero) begin
                    x_d     = sh_q[WIDTH-1];
                    sh_d    = {sh_q[WIDTH-2:0], 1'b0};
                    bit_dec = 1'b1;
                end else if (!rep_zero) begin
                    rep_dec = 1'b1;
                    if (GAP > 0) begin
                        state_d = S_GAP;
                        gap_ld  = 1'b1;
                    end else begin
                        reload = 1'b1;
                    end
                end else begin
                    state_d = S_DONE;
                end
            end
            S_GAP: begin
                if (gap_zero) begin
                    reload = 1'b1;
                end else begin
                    gap_dec = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Restart a repetition from the captured pattern with no bubble
        if (reload) begin
            state_d = S_SHIFT;
            x_d     = pat_q[WIDTH-1];
            sh_d    = {pat_q[WIDTH-2:0], 1'b0};
            bit_ld  = 1'b1;
        end

        busy_d = (state_d == S_SHIFT) || (state_d == S_GAP);
        done_d = (state_d == S_DONE);
    end

    assign x    = x_q;
    assign busy = busy_q;
    assign done = done_q;
    assign out  = state_q;

endmodule

// File: tb/tb_moore_seq_gen.sv
// Bench for moore_seq_gen: GAP=2 and GAP=0 instances checked cycle by cycle
// against an expected-waveform queue built from the pattern/len/reps rules.
module tb_moore_seq_gen;
    import moore_seq_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] pattern;
    logic [4:0]  len;
    logic [3:0]  reps;
    logic        x0, busy0, done0;
    logic [2:0]  out0;
    logic        x2, busy2, done2;
    logic [2:0]  out2;

    int checks   = 0;
    int failures = 0;

    // Each entry: {state code, x bit} for one busy cycle after the start edge
    logic [3:0] q0[$];
    logic [3:0] q2[$];

    moore_seq_gen #(.WIDTH(16), .LEN_W(5), .REP_W(4), .GAP(0)) dut0 (
        .clk(clk), .reset(reset), .start(start), .pattern(pattern), .len(len),
        .reps(reps), .x(x0), .busy(busy0), .done(done0), .out(out0)
    );

    moore_seq_gen #(.WIDTH(16), .LEN_W(5), .REP_W(4), .GAP(2)) dut2 (
        .clk(clk), .reset(reset), .start(start), .pattern(pattern), .len(len),
        .reps(reps), .x(x2), .busy(busy2), .done(done2), .out(out2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int k, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d obs=%0d exp=%0d", tag, k, obs, exp);
        end
    endtask

    task automatic build(input logic [15:0] p, input int ln, input int rp);
        int n;
        n = (ln > 16) ? 16 : ln;
        q0.delete();
        q2.delete();
        if (n > 0) begin
            for (int r = 0; r <= rp; r++) begin
                for (int i = n - 1; i >= 0; i--) begin
                    q0.push_back({S_SHIFT, p[i]});
                    q2.push_back({S_SHIFT, p[i]});
                end
                if (r < rp) begin
                    for (int g = 0; g < 2; g++) q2.push_back({S_GAP, 1'b0});
                end
            end
        end
    endtask

    task automatic check_cycle(input int k, input bit held);
        for (int d = 0; d < 2; d++) begin
            int sz;
            int m;
            logic [3:0] e;
            logic ex, eb, ed;
            logic [2:0] eo;
            sz = (d == 0) ? q0.size() : q2.size();
            m  = held ? ((k - 1) % (sz + 2)) + 1 : k;
            if (m <= sz) begin
                e  = (d == 0) ? q0[m-1] : q2[m-1];
                ex = e[0]; eo = e[3:1]; eb = 1'b1; ed = 1'b0;
            end else if (m == sz + 1) begin
                ex = 1'b0; eo = S_DONE; eb = 1'b0; ed = 1'b1;
            end else begin
                ex = 1'b0; eo = S_IDLE; eb = 1'b0; ed = 1'b0;
            end
            if (d == 0) begin
                chk("g0_x",    k, {2'b0, x0},    {2'b0, ex});
                chk("g0_busy", k, {2'b0, busy0}, {2'b0, eb});
                chk("g0_done", k, {2'b0, done0}, {2'b0, ed});
                chk("g0_out",  k, out0, eo);
            end else begin
                chk("g2_x",    k, {2'b0, x2},    {2'b0, ex});
                chk("g2_busy", k, {2'b0, busy2}, {2'b0, eb});
                chk("g2_done", k, {2'b0, done2}, {2'b0, ed});
                chk("g2_out",  k, out2, eo);
            end
        end
    endtask

    task automatic check_idle(input string tag, input int k);
        chk({tag, "_x0"},    k, {2'b0, x0},    3'd0);
        chk({tag, "_busy0"}, k, {2'b0, busy0}, 3'd0);
        chk({tag, "_done0"}, k, {2'b0, done0}, 3'd0);
        chk({tag, "_out0"},  k, out0,          S_IDLE);
        chk({tag, "_x2"},    k, {2'b0, x2},    3'd0);
        chk({tag, "_busy2"}, k, {2'b0, busy2}, 3'd0);
        chk({tag, "_done2"}, k, {2'b0, done2}, 3'd0);
        chk({tag, "_out2"},  k, out2,          S_IDLE);
    endtask

    // One transmission (or a held-start train); inputs scrambled while busy unless held
    task automatic run_txn(input logic [15:0] p, input logic [4:0] ln, input logic [3:0] rp,
                           input bit poke, input bit held, input int ncyc_in);
        int n;
        int mn;
        build(p, int'(ln), int'(rp));
        mn = (q0.size() < q2.size()) ? q0.size() : q2.size();
        n  = ncyc_in;
        if (n == 0) n = ((q0.size() > q2.size()) ? q0.size() : q2.size()) + 3;
        pattern = p;
        len     = ln;
        reps    = rp;
        start   = 1'b1;
        step();
        start = held;
        for (int k = 1; k <= n; k++) begin
            check_cycle(k, held);
            if (!held) begin
                start   = poke && ((k == 2) || (k == 4)) && (k <= mn);
                pattern = 16'($urandom);
                len     = 5'($urandom);
                reps    = 4'($urandom);
            end
            step();
        end
        if (held) begin
            start = 1'b0;
            reset = 1'b1;
            step();
            reset = 1'b0;
        end
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        pattern = '0;
        len     = '0;
        reps    = '0;
        step();
        step();
        check_idle("reset", 0);
        reset = 1'b0;

        run_txn(16'h0015, 5'd5, 4'd0, 1'b0, 1'b0, 0);
        run_txn(16'h0015, 5'd5, 4'd1, 1'b0, 1'b0, 0);
        run_txn(16'h0015, 5'd5, 4'd2, 1'b0, 1'b0, 0);
        run_txn(16'hFFFF, 5'd0, 4'd3, 1'b0, 1'b0, 0);
        run_txn(16'hA5C3, 5'd31, 4'd0, 1'b0, 1'b0, 0);
        run_txn(16'h0015, 5'd5, 4'd0, 1'b1, 1'b0, 0);
        run_txn(16'h0005, 5'd3, 4'd15, 1'b0, 1'b0, 0);
        for (int t = 0; t < 8; t++) begin
            run_txn(16'($urandom), 5'($urandom), 4'($urandom_range(0, 3)), 1'b1, 1'b0, 0);
        end

        // Reset mid-transmission: no further bits and no done pulse
        build(16'h0015, 5, 0);
        pattern = 16'h0015;
        len     = 5'd5;
        reps    = 4'd0;
        start   = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            check_cycle(k, 1'b0);
            if (k == 3) reset = 1'b1;
            step();
        end
        reset = 1'b0;
        for (int k = 4; k <= 10; k++) begin
            check_idle("midreset", k);
            step();
        end

        run_txn(16'h0015, 5'd5, 4'd0, 1'b0, 1'b1, 2 * (5 + 2) + 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
